change_logger: RTL

- Hardware counterpart to the simulator's value-change dump: watches one data word and records every change as a {timestamp, value} pair.
- Records go into a small FIFO and are drained over a valid/ready stream by a downstream formatter or UART bridge.
- Sits beside the block under observation (e.g. on the data_out of the 8-bit datapath) so on-chip waveforms can be exported in the same change-list form the SVG tooling consumes.

---
 rtl/change_logger_pkg.sv | 43 ++++
 rtl/change_logger_fifo.sv | 87 ++++++++
 rtl/change_logger.sv | 120 ++++++++++++
 3 files changed

// File: rtl/change_logger_pkg.sv
// rtl/change_logger_pkg.sv - record layout and shared constants for the change logger
//
// Purpose: single place that defines how a {wrap, timestamp, value} record is
// packed into a flat word, so the logger, its FIFO and any consumer agree.
// Layout (LSB first): data[DATA_W-1:0], time[TS_W-1:0], wrap.
// No ports (package).
package change_logger_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_TS_W   = 16;
    localparam int DEF_DEPTH  = 16;

    // Layout helpers usable with any parameterisation of the logger.
    function automatic int rec_width(input int data_w, input int ts_w);
        return ts_w + data_w + 1;
    endfunction

    function automatic int rec_data_lsb();
        return 0;
    endfunction

    function automatic int rec_time_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int rec_wrap_bit(input int data_w, input int ts_w);
        return data_w + ts_w;
    endfunction

    // Offsets for the default parameterisation.
    localparam int REC_W        = DEF_TS_W + DEF_DATA_W + 1;
    localparam int REC_DATA_LSB = 0;
    localparam int REC_TIME_LSB = DEF_DATA_W;
    localparam int REC_WRAP_BIT = DEF_DATA_W + DEF_TS_W;

    // Record as seen by consumers of the default build.
    typedef struct packed {
        logic                  wrap;
        logic [DEF_TS_W-1:0]   ts;
        logic [DEF_DATA_W-1:0] data;
    } rec_t;

endpackage

// File: rtl/change_logger_fifo.sv
// rtl/change_logger_fifo.sv - show-ahead record FIFO with explicit occupancy count
//
// Purpose: stores logger records; head entry is presented combinationally.
// Ports:
//   clk_i        clock (rising edge)
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous flush; blocks push and pop on that edge
//   push_i       push request
//   push_data_i  record to push
//   pop_i        pop request (ignored while empty)
//   valid_o      head holds a record
//   data_o       head record (zero while empty)
//   dropped_o    push request refused because full with no pop
module change_logger_fifo
    import change_logger_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             dropped_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    always_comb begin
        pop_en    = pop_i && !clr_i && (count_q != '0);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_en   = push_i && !clr_i && ((count_q != DEPTH_C) || pop_en);
        dropped_o = push_i && !clr_i && !push_en;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are qualified by count_q.
    always_ff @(posedge clk_i) begin
        if (push_en) mem[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/change_logger.sv
// rtl/change_logger.sv - value-change logger producing {timestamp, value} records
//
// Purpose: watches data_in, logs the initial value and every change with the
// cycle timestamp, plus a wrap marker when the timestamp rolls over unchanged.
// Ports:
//   clock      clock (rising edge)
//   reset_n    asynchronous active-low reset
//   enable     logging enable; timestamp advances only while set
//   clear      synchronous flush/re-arm, highest priority
//   data_in    monitored word
//   rec_valid  head record available
//   rec_ready  consumer accepts head record
//   rec_time   head record timestamp
//   rec_data   head record value
//   rec_wrap   head record is a timestamp-wrap marker
//   overflow   sticky: a record was dropped since reset/clear
module change_logger
    import change_logger_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [TS_W-1:0]   rec_time,
    output logic [DATA_W-1:0] rec_data,
    output logic              rec_wrap,
    output logic              overflow
);

    localparam int RW       = rec_width(DATA_W, TS_W);
    localparam int DATA_LSB = rec_data_lsb();
    localparam int TIME_LSB = rec_time_lsb(DATA_W);
    localparam int WRAP_BIT = rec_wrap_bit(DATA_W, TS_W);

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              armed_q, armed_d;
    logic              ovf_q, ovf_d;

    logic              changed, at_ts_max;
    logic              push, push_wrap;
    logic [RW-1:0]     push_rec;
    logic              fifo_valid, fifo_dropped;
    logic [RW-1:0]     fifo_data;

    assign changed   = (data_in != prev_q);
    assign at_ts_max = (ts_q == {TS_W{1'b1}});

    always_comb begin
        ts_d      = ts_q;
        prev_d    = prev_q;
        armed_d   = armed_q;
        push      = 1'b0;
        push_wrap = 1'b0;
        if (clear) begin
            // prev is deliberately kept; the re-armed sample logs the value anyway.
            ts_d    = '0;
            armed_d = 1'b1;
        end else if (enable) begin
            push      = armed_q || changed || at_ts_max;
            // Only a pure rollover with no other reason to log is a wrap marker.
            push_wrap = !armed_q && !changed;
            ts_d      = ts_q + TS_W'(1);
            prev_d    = data_in;
            armed_d   = 1'b0;
        end
    end

    // When push_wrap is set data_in equals prev_q, so data_in serves both cases.
    assign push_rec = {push_wrap, ts_q, data_in};

    always_comb begin
        ovf_d = ovf_q;
        if (clear)             ovf_d = 1'b0;
        else if (fifo_dropped) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q    <= '0;
            prev_q  <= '0;
            armed_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            ovf_q   <= ovf_d;
        end
    end

    change_logger_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .clr_i       (clear),
        .push_i      (push),
        .push_data_i (push_rec),
        .pop_i       (rec_ready),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .dropped_o   (fifo_dropped)
    );

    assign rec_valid = fifo_valid;
    assign rec_data  = fifo_data[DATA_LSB +: DATA_W];
    assign rec_time  = fifo_data[TIME_LSB +: TS_W];
    assign rec_wrap  = fifo_data[WRAP_BIT];
    assign overflow  = ovf_q;

endmodule
